// File: rtl/io_link_pkg.sv
// Shared types for the IO link merge: direction encoding, the ready_and link
// layout and the position of the last-beat flag.
package io_link_pkg;

    typedef enum logic [2:0] {
        p_e = 3'd0,
        w_e = 3'd1,
        e_e = 3'd2,
        n_e = 3'd3,
        s_e = 3'd4
    } dirs_e;

    localparam int unsigned io_data_width_lp = 66;
    localparam int unsigned io_last_bit_lp   = io_data_width_lp - 1;

    typedef struct packed {
        logic                        v;
        logic                        ready_and_rev;
        logic [io_data_width_lp-1:0] data;
    } bp_io_ready_and_link_t;

    typedef enum logic {
        arb_idle,
        arb_locked
    } arb_state_e;

endpackage

// File: rtl/link_fifo.sv
// Small ready_and FIFO with no bypass path. Ready reflects registered occupancy
// only, so a full FIFO refuses a beat even if it is being drained that cycle.
module link_fifo #(
    parameter int unsigned els_p        = 2,
    parameter int unsigned data_width_p = 66
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [data_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned count_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0]   ptr_max_lp    = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    logic [data_width_p-1:0]   mem_q [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    assign ready_o = ~reset_i & (count_q != full_count_lp);
    assign v_o     = ~reset_i & (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == ptr_max_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_max_lp) ? '0 : rd_ptr_q + ptr_width_lp'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/io_link_merge.sv
// Merges the west and east IO links into the P link, forwarding whole
// multi-beat packets with a round-robin choice between packets.
module io_link_merge
    import io_link_pkg::*;
#(
    parameter int unsigned data_width_p    = io_data_width_lp,
    parameter int unsigned els_p           = 2,
    localparam int unsigned link_width_lp  = data_width_p + 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [2:1][link_width_lp-1:0] link_i,
    output logic [2:1][link_width_lp-1:0] link_o,
    output logic [link_width_lp-1:0]      link_p_o,
    input  logic [link_width_lp-1:0]      link_p_i
);

    localparam int unsigned v_bit_lp    = link_width_lp - 1;
    localparam int unsigned rdy_bit_lp  = data_width_p;
    localparam int unsigned last_bit_lp = data_width_p - 1;

    logic [2:1]                   fifo_ready;
    logic [2:1]                   fifo_v;
    logic [2:1]                   fifo_yumi;
    logic [2:1][data_width_p-1:0] fifo_data;

    for (genvar d = int'(w_e); d <= int'(e_e); d++) begin : g_in
        link_fifo #(
            .els_p        (els_p),
            .data_width_p (data_width_p)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (link_i[d][v_bit_lp]),
            .data_i  (link_i[d][data_width_p-1:0]),
            .ready_o (fifo_ready[d]),
            .v_o     (fifo_v[d]),
            .data_o  (fifo_data[d]),
            .yumi_i  (fifo_yumi[d])
        );

        assign link_o[d] = {1'b0, fifo_ready[d], {data_width_p{1'b0}}};
    end

    arb_state_e                state_q, state_d;
    dirs_e                     grant_q, grant_d;
    dirs_e                     last_q, last_d;
    dirs_e                     hold_dir_q, hold_dir_d;
    logic                      hold_q, hold_d;
    dirs_e                     cand, sel;
    logic                      out_v, out_last, xfer;
    logic [data_width_p-1:0]   out_data;

    // A stalled offer pins its direction so a late arrival cannot steal it.
    always_comb begin
        if (hold_q) begin
            cand = hold_dir_q;
        end else if (last_q == w_e) begin
            cand = fifo_v[2] ? e_e : w_e;
        end else begin
            cand = fifo_v[1] ? w_e : e_e;
        end
    end

    always_comb begin
        sel = (state_q == arb_locked) ? grant_q : cand;
        if (sel == e_e) begin
            out_v    = fifo_v[2];
            out_data = fifo_data[2];
        end else begin
            out_v    = fifo_v[1];
            out_data = fifo_data[1];
        end
        out_last     = out_data[last_bit_lp];
        xfer         = out_v & link_p_i[rdy_bit_lp];
        fifo_yumi    = '0;
        fifo_yumi[1] = xfer & (sel != e_e);
        fifo_yumi[2] = xfer & (sel == e_e);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_d     = hold_q;
        hold_dir_d = hold_dir_q;
        case (state_q)
            arb_idle: begin
                if (xfer) begin
                    last_d = cand;
                    hold_d = 1'b0;
                    if (!out_last) begin
                        state_d = arb_locked;
                        grant_d = cand;
                    end
                end else if (out_v) begin
                    hold_d     = 1'b1;
                    hold_dir_d = cand;
                end
            end
            arb_locked: begin
                if (xfer && out_last) begin
                    state_d = arb_idle;
                end
            end
            default: state_d = arb_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= arb_idle;
            grant_q    <= w_e;
            last_q     <= e_e;
            hold_q     <= 1'b0;
            hold_dir_q <= w_e;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            hold_dir_q <= hold_dir_d;
        end
    end

    assign link_p_o = reset_i ? '0 : {out_v, 1'b0, out_data};

    logic unused_link;
    assign unused_link = ^{link_p_i[v_bit_lp], link_p_i[data_width_p-1:0],
                           link_i[1][rdy_bit_lp], link_i[2][rdy_bit_lp]};

endmodule

// File: tb/tb_io_link_merge.sv
// Randomised bench for io_link_merge with a queue-based reference model and a
// few directed scenarios whose output order is pinned with literal values.
module tb_io_link_merge;
    import io_link_pkg::*;

    localparam int DW  = 66;
    localparam int LW  = DW + 2;
    localparam int ELS = 2;
    localparam logic [DW-1:0] LB = {1'b1, {(DW-1){1'b0}}};

    logic                clk = 1'b0;
    logic                reset_i;
    logic [2:1][LW-1:0]  link_i;
    logic [2:1][LW-1:0]  link_o;
    logic [LW-1:0]       link_p_o;
    logic [LW-1:0]       link_p_i;

    io_link_merge #(
        .data_width_p (DW),
        .els_p        (ELS)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .link_i   (link_i),
        .link_o   (link_o),
        .link_p_o (link_p_o),
        .link_p_i (link_p_i)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // stimulus state
    logic [DW-1:0] snd_q [2:1][$];
    bit            pres  [2:1];
    bit            dir_mode  = 1'b1;
    int            cons_mode = 0;
    bit            rst_req   = 1'b1;
    int            cyc       = 0;

    // reference model: FIFO contents and packet arbitration in plain terms
    logic [DW-1:0] mq [2:1][$];
    bit            m_lock     = 1'b0;
    int            m_grant    = 1;
    int            m_last     = 2;
    bit            m_hold     = 1'b0;
    int            m_hold_dir = 1;

    // observations from the most recent cycle
    logic          p_v;
    logic [DW-1:0] p_data;
    logic [2:1]    p_rdy;
    logic [DW-1:0] lg [$];
    int            lg_cyc [$];
    logic [DW-1:0] ex [$];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, LW'(lg.size()), LW'(ex.size()));
        for (int i = 0; i < ex.size() && i < lg.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), lg[i], ex[i]);
        end
    endtask

    task automatic gen_pkt(input int d, input int len);
        logic [DW-1:0] x;
        for (int i = 0; i < len; i++) begin
            x[31:0]          = $urandom();
            x[63:32]         = $urandom();
            x[64]            = 1'($urandom_range(0, 1));
            x[io_last_bit_lp] = (i == len - 1);
            snd_q[d].push_back(x);
        end
    endtask

    task automatic step();
        bit                    er [2:1];
        bit                    ev;
        bit                    crdy;
        int                    sel;
        logic [DW-1:0]         b;
        bp_io_ready_and_link_t po;

        @(negedge clk);
        reset_i = rst_req;
        for (int d = 1; d <= 2; d++) begin
            if (!pres[d] && snd_q[d].size() > 0 && (dir_mode || $urandom_range(0, 3) != 0)) begin
                pres[d] = 1'b1;
            end
            link_i[d] = pres[d] ? {1'b1, 1'b0, snd_q[d][0]} : '0;
        end
        case (cons_mode)
            0:       crdy = 1'b1;
            1:       crdy = ($urandom_range(0, 2) != 0);
            default: crdy = 1'b0;
        endcase
        link_p_i = {1'b0, crdy, {DW{1'b0}}};
        #1;

        ev  = 1'b0;
        sel = 1;
        for (int d = 1; d <= 2; d++) er[d] = !rst_req && (mq[d].size() < ELS);
        if (!rst_req) begin
            if (m_lock) begin
                sel = m_grant;
                ev  = (mq[sel].size() > 0);
            end else if (mq[1].size() > 0 || mq[2].size() > 0) begin
                ev = 1'b1;
                if (m_hold) begin
                    sel = m_hold_dir;
                end else begin
                    sel = (m_last == 1) ? 2 : 1;
                    if (mq[sel].size() == 0) sel = 3 - sel;
                end
            end
        end

        po = link_p_o;
        for (int d = 1; d <= 2; d++) begin
            chk($sformatf("link_o_%0d", d), link_o[d], {1'b0, er[d], {DW{1'b0}}});
        end
        chk("p_v", LW'(po.v), LW'(ev));
        if (ev) chk("p_data", LW'(po.data), LW'(mq[sel][0]));
        if (rst_req) chk("p_reset", link_p_o, '0);

        p_v    = po.v;
        p_data = po.data;
        for (int d = 1; d <= 2; d++) p_rdy[d] = link_o[d][DW];
        if (po.v && crdy) begin
            lg.push_back(po.data);
            lg_cyc.push_back(cyc);
        end

        if (rst_req) begin
            mq[1].delete();
            mq[2].delete();
            m_lock = 1'b0;
            m_last = 2;
            m_hold = 1'b0;
        end else begin
            if (ev && crdy) begin
                b = mq[sel].pop_front();
                if (!m_lock) begin
                    m_last = sel;
                    m_hold = 1'b0;
                    if (!b[io_last_bit_lp]) begin
                        m_lock  = 1'b1;
                        m_grant = sel;
                    end
                end else if (b[io_last_bit_lp]) begin
                    m_lock = 1'b0;
                end
            end else if (ev && !m_lock) begin
                m_hold     = 1'b1;
                m_hold_dir = sel;
            end
            for (int d = 1; d <= 2; d++) begin
                if (pres[d] && er[d]) begin
                    mq[d].push_back(snd_q[d].pop_front());
                    pres[d] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        reset_i  = 1'b1;
        link_i   = '0;
        link_p_i = '0;
        pres[1]  = 1'b0;
        pres[2]  = 1'b0;

        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;

        // single-beat tie: W wins first, then strict alternation, one per cycle
        for (int i = 0; i < 4; i++) begin
            snd_q[1].push_back(LB | DW'('hB0 + i));
            snd_q[2].push_back(LB | DW'('hC0 + i));
        end
        lg.delete();
        lg_cyc.delete();
        repeat (12) step();
        ex.delete();
        for (int i = 0; i < 4; i++) begin
            ex.push_back(LB | DW'('hB0 + i));
            ex.push_back(LB | DW'('hC0 + i));
        end
        chk_log("tie");
        if (lg_cyc.size() == 8) chk("tie_rate", LW'(lg_cyc[7] - lg_cyc[0]), LW'(7));

        // latency: no bypass from input to output
        snd_q[1].push_back(LB | DW'('hA1));
        step();
        chk("lat_same_cycle_v", LW'(p_v), LW'(0));
        step();
        chk("lat_next_cycle_v", LW'(p_v), LW'(1));
        chk("lat_next_cycle_data", LW'(p_data), LW'(LB | DW'('hA1)));
        repeat (2) step();

        // packet lock: E arrives mid-packet and must wait for W's last beat
        lg.delete();
        snd_q[1].push_back(DW'('hD0));
        snd_q[1].push_back(DW'('hD1));
        snd_q[1].push_back(LB | DW'('hD2));
        step();
        snd_q[2].push_back(LB | DW'('hE0));
        repeat (8) step();
        ex.delete();
        ex.push_back(DW'('hD0));
        ex.push_back(DW'('hD1));
        ex.push_back(LB | DW'('hD2));
        ex.push_back(LB | DW'('hE0));
        chk_log("lock");

        // backpressure, then release while the W FIFO is full
        lg.delete();
        cons_mode = 2;
        snd_q[1].push_back(DW'('hF0));
        snd_q[1].push_back(DW'('hF1));
        snd_q[1].push_back(DW'('hF2));
        snd_q[1].push_back(LB | DW'('hF3));
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k >= 2) chk("bp_hold_data", LW'(p_data), LW'(DW'('hF0)));
            if (k >= 3) chk("bp_w_ready", LW'(p_rdy[1]), LW'(0));
        end
        cons_mode = 0;
        step();
        chk("full_deq_ready", LW'(p_rdy[1]), LW'(0));
        chk("full_deq_v", LW'(p_v), LW'(1));
        step();
        chk("after_deq_ready", LW'(p_rdy[1]), LW'(1));
        repeat (6) step();
        ex.delete();
        ex.push_back(DW'('hF0));
        ex.push_back(DW'('hF1));
        ex.push_back(DW'('hF2));
        ex.push_back(LB | DW'('hF3));
        chk_log("bp");

        // reset in the middle of a locked W packet
        snd_q[1].push_back(DW'('h10));
        snd_q[1].push_back(LB | DW'('h11));
        repeat (2) step();
        snd_q[1].delete();
        snd_q[2].delete();
        pres[1] = 1'b0;
        pres[2] = 1'b0;
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        step();
        chk("rst_p_v", LW'(p_v), LW'(0));
        chk("rst_w_ready", LW'(p_rdy[1]), LW'(1));
        chk("rst_e_ready", LW'(p_rdy[2]), LW'(1));
        lg.delete();
        snd_q[1].push_back(66'h1_0000_0001);
        snd_q[2].push_back(LB | DW'('h20));
        step();
        chk("rst_new_same_cycle_v", LW'(p_v), LW'(0));
        step();
        chk("rst_new_v", LW'(p_v), LW'(1));
        chk("rst_new_data", LW'(p_data), LW'(66'h1_0000_0001));
        snd_q[1].push_back(LB | DW'('h12));
        repeat (5) step();
        ex.delete();
        ex.push_back(66'h1_0000_0001);
        ex.push_back(LB | DW'('h12));
        ex.push_back(LB | DW'('h20));
        chk_log("rst_pkt");

        // random traffic with a random consumer and one mid-run reset
        dir_mode  = 1'b0;
        cons_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 1; d <= 2; d++) begin
                if (snd_q[d].size() < 4 && $urandom_range(0, 2) == 0) begin
                    gen_pkt(d, $urandom_range(1, 4));
                end
            end
            rst_req = (c >= 1500 && c < 1502);
            step();
        end
        rst_req   = 1'b0;
        cons_mode = 0;
        dir_mode  = 1'b1;
        repeat (100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
